fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the single-cycle LEGv8 core.
- Reads each 32-bit instruction one byte per cycle from a byte-wide instruction memory and assembles it little-endian.
- Presents the instruction and its PC to decode with a valid/ready handshake, then applies the decode PCSrc/BranchAddress redirect.
- Detects HALT and address faults; replaces the testbench-style fetch loop.

Parameters:
- ADDR_W, 64, PC and memory address width.
- IMEM_BYTES, 4096, instruction memory size in bytes; highest legal word address is IMEM_BYTES-4.
- NOP_WORD, 32'hD503201F, instruction word presented after reset before the first fetch completes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_rd  out  1  byte read request.
- imem_addr  out  ADDR_W  byte address of the request.
- imem_rdata  in  8  byte for the request issued in the previous cycle (fixed 1-cycle read latency).
- inst_out  out  32  assembled instruction.
- pc_out  out  ADDR_W  byte address of inst_out.
- inst_valid  out  1  inst_out/pc_out are valid.
- inst_ready  in  1  decode accepts the instruction.
- pc_src  in  1  PCSrc from decode; sampled only on the accept edge.
- branch_addr  in  ADDR_W  BranchAddress from decode; sampled only on the accept edge.
- halted  out  1  HALT retired; sticky until reset.
- fault  out  1  illegal next-PC; sticky until reset.

Behaviour:
- Reset values: pc=0, inst_out=NOP_WORD, pc_out=0, inst_valid=0, imem_rd=0, imem_addr=0, halted=0, fault=0, state=FETCH, cnt=0.
- Reset is asynchronous. Asserting it mid-fetch discards partial bytes; fetch restarts at PC 0 on the first edge after deassertion.
- States: FETCH, DRAIN, VALID, HALTED, FAULT.
- FETCH:
  - imem_rd=1, imem_addr=pc+cnt, for cnt 0..3, one byte per cycle.
  - The byte returned for request i is written to inst_out lane [8i+7:8i] on the following edge.
  - After cnt=3 the state moves to DRAIN.
- DRAIN: imem_rd=0. Byte 3 is captured, pc_out=pc, inst_valid is set, and the state moves to VALID.
- Latency: inst_valid rises on the 5th edge after entry to FETCH. Best-case throughput is one instruction per 6 cycles with inst_ready held high.
- VALID:
  - inst_out and pc_out stay stable while inst_ready=0. inst_out is not overwritten before acceptance.
  - Accept edge is (inst_valid & inst_ready). On that edge inst_valid clears and next = pc_src ? branch_addr : pc+4, computed mod 2^ADDR_W.
  - If inst_out[31:21]==11'h7FF (HALT): go to HALTED and set halted=1. The branch is ignored and no further imem_rd is issued.
  - Else if next[1:0]!=0 or next>IMEM_BYTES-4 (this includes wrap-around): go to FAULT and set fault=1. pc is unchanged and no imem_rd is issued.
  - Else: pc=next, cnt=0, go to FETCH.
- HALTED and FAULT are terminal; only rst_n exits them. Outputs hold their last values and inst_valid=0.
- pc_src and branch_addr are don't-care outside the accept edge.
- NOP_WORD is visible on inst_out until the first DRAIN overwrites it. inst_valid stays 0 during that time, so decode never consumes it as a real instruction.

Decomposition:
- Shared package fetch_pkg:
  - State enum.
  - NOP_WORD constant.
  - HALT_OPC=11'h7FF and the HALT field position [31:21].
  - IMEM_BYTES default.
- One natural sub-module, byte_lane_assembler. It holds a 2-bit lane index, performs lane-select writes into the 32-bit register, and presets to NOP_WORD on reset. The FSM, PC register and range check stay in fetch_sequencer.

Test Plan:
- Reset/sequential: memory holds 8B000000 at byte 0 and 8B010000 at byte 4; inst_ready=1, pc_src=0. Expect imem_addr 0,1,2,3 on consecutive cycles, then inst_out=32'h8B000000, pc_out=0, inst_valid on the 5th edge, then pc_out=4.
- Backpressure: hold inst_ready=0 for 7 cycles in VALID. Expect inst_out, pc_out and inst_valid stable, imem_rd=0, and PC advancing only on the first edge with ready=1.
- Branch: accept at pc_out=8 with pc_src=1, branch_addr=0x40. Expect next fetch addresses 0x40..0x43 and pc_out=0x40; branch_addr changes outside the accept edge have no effect.
- HALT: word 0xFFE00000 at address 0x0C. Expect it presented with inst_valid, then halted=1 after accept, imem_rd held at 0 for 20 cycles, and pc_src=1 ignored.
- Fault: branch_addr=0x42 gives fault=1. Separately, branch_addr=0xFFC (=IMEM_BYTES-4) is legal, and a sequential fetch after it (next 0x1000) gives fault=1.
- Mid-fetch reset: drop rst_n in FETCH with cnt=2. Expect outputs at reset values immediately without waiting for a clock, inst_out=NOP_WORD, and a refetch from address 0 after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 fetch sequencer.
//   fetch_state_e     : sequencer FSM states
//   NopWord           : word shown on inst_out before the first fetch completes
//   HaltOpc / HaltMsb / HaltLsb : HALT opcode and its field position
//   ImemBytesDefault  : default instruction memory size in bytes
package fetch_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDrain,
    StValid,
    StHalted,
    StFault
  } fetch_state_e;

  localparam logic [31:0] NopWord          = 32'hD503201F;
  localparam logic [10:0] HaltOpc          = 11'h7FF;
  localparam int unsigned HaltMsb          = 31;
  localparam int unsigned HaltLsb          = 21;
  localparam int unsigned ImemBytesDefault = 4096;

  function automatic logic is_halt(input logic [31:0] word);
    return word[HaltMsb:HaltLsb] == HaltOpc;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: byte-wide instruction memory port plus the decode-side
// valid/ready handshake with the PCSrc/BranchAddress redirect.
//   master : the fetch sequencer
//   slave  : memory + decode (or a testbench standing in for them)
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 64
) ();

  logic              imem_rd;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_rdata;
  logic [31:0]       inst_out;
  logic [ADDR_W-1:0] pc_out;
  logic              inst_valid;
  logic              inst_ready;
  logic              pc_src;
  logic [ADDR_W-1:0] branch_addr;

  modport master (
    output imem_rd, imem_addr, inst_out, pc_out, inst_valid,
    input  imem_rdata, inst_ready, pc_src, branch_addr
  );

  modport slave (
    input  imem_rd, imem_addr, inst_out, pc_out, inst_valid,
    output imem_rdata, inst_ready, pc_src, branch_addr
  );

endinterface

// File: rtl/fetch_sequencer_byte_lane_assembler.sv
// Assembles a 32-bit little-endian word from successive bytes.
//   clk, rst_n : clock, asynchronous active-low reset (presets word to NOP_WORD)
//   wr_en      : write wr_byte into the current lane, then advance the lane
//   wr_byte    : incoming byte
//   word       : assembled word
module byte_lane_assembler
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NopWord
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_byte,
  output logic [31:0] word
);

  logic [1:0]  lane_q;
  logic [31:0] word_q;

  // Lane index wraps after byte 3, so each new fetch starts at lane 0 without a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= 2'd0;
      word_q <= NOP_WORD;
    end else if (wr_en) begin
      word_q[{lane_q, 3'b000} +: 8] <= wr_byte;
      lane_q                        <= lane_q + 2'd1;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the single-cycle LEGv8 core.
// Reads four bytes per instruction from a byte-wide memory (1-cycle latency),
// presents instruction + PC to decode with valid/ready, applies the redirect on
// the accept edge, and stops on HALT or on an illegal next PC.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_sequencer_if.master (memory port + decode handshake)
//   halted     : HALT retired, sticky until reset
//   fault      : illegal next PC, sticky until reset
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned IMEM_BYTES = ImemBytesDefault,
  parameter logic [31:0] NOP_WORD   = NopWord
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_sequencer_if.master  bus,
  output logic               halted,
  output logic               fault
);

  localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(IMEM_BYTES - 4);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [1:0]        cnt_q;
  logic              imem_rd_q;
  logic              inst_valid_q;
  logic              halted_q;
  logic              fault_q;

  logic [31:0]       inst_word;
  logic [ADDR_W-1:0] next_pc;
  logic              next_bad;
  logic              accept;

  // A request registered on one edge returns its byte in time for the next edge,
  // so the registered read strobe doubles as the capture enable.
  byte_lane_assembler #(
    .NOP_WORD (NOP_WORD)
  ) u_asm (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (imem_rd_q),
    .wr_byte (bus.imem_rdata),
    .word    (inst_word)
  );

  assign accept   = inst_valid_q & bus.inst_ready;
  assign next_pc  = bus.pc_src ? bus.branch_addr : pc_q + ADDR_W'(4);
  assign next_bad = (next_pc[1:0] != 2'b00) || (next_pc > LastWord);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      pc_q         <= '0;
      pc_out_q     <= '0;
      imem_addr_q  <= '0;
      cnt_q        <= 2'd0;
      imem_rd_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          imem_rd_q   <= 1'b1;
          imem_addr_q <= pc_q + ADDR_W'(cnt_q);
          cnt_q       <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= StDrain;
        end
        StDrain: begin
          // Byte 3 lands in the assembler on this edge.
          imem_rd_q    <= 1'b0;
          pc_out_q     <= pc_q;
          inst_valid_q <= 1'b1;
          state_q      <= StValid;
        end
        StValid: begin
          if (accept) begin
            inst_valid_q <= 1'b0;
            if (is_halt(inst_word)) begin
              halted_q <= 1'b1;
              state_q  <= StHalted;
            end else if (next_bad) begin
              fault_q <= 1'b1;
              state_q <= StFault;
            end else begin
              pc_q    <= next_pc;
              cnt_q   <= 2'd0;
              state_q <= StFetch;
            end
          end
        end
        StHalted, StFault: begin
          imem_rd_q    <= 1'b0;
          inst_valid_q <= 1'b0;
        end
        default: begin
          imem_rd_q    <= 1'b0;
          inst_valid_q <= 1'b0;
          fault_q      <= 1'b1;
          state_q      <= StFault;
        end
      endcase
    end
  end

  assign bus.imem_rd    = imem_rd_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.inst_out   = inst_word;
  assign bus.pc_out     = pc_out_q;
  assign bus.inst_valid = inst_valid_q;
  assign halted         = halted_q;
  assign fault          = fault_q;

endmodule
